// File: rtl/result_select_buf.sv
// Arbitrates the add/sub and multiplier result streams into a 2-entry FIFO
// that feeds the register-file write port.
module result_select_buf #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] as_data,
    input  logic         as_valid,
    output logic         as_ready,
    input  logic [W-1:0] mul_data,
    input  logic         mul_valid,
    output logic         mul_ready,
    input  logic [1:0]   sel_mode,
    input  logic         ext_signed,
    output logic [W-1:0] out_data,
    output logic         out_src,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    localparam logic [1:0] MODE_AS  = 2'b00;
    localparam logic [1:0] MODE_MUL = 2'b01;
    localparam logic [1:0] MODE_RR  = 2'b10;
    localparam logic [1:0] MODE_PRI = 2'b11;

    function automatic logic [W-1:0] extend(input logic [N-1:0] d, input logic sgn);
        logic signed [N-1:0] sd;
        sd = signed'(d);
        if (sgn)
            return W'(sd);
        else
            return W'(d);
    endfunction

    logic [W-1:0] buf_data_p1 [2];
    logic         buf_src_p1  [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         rr_last;

    logic         can_push;
    logic         grant_as;
    logic         grant_mul;
    logic         push;
    logic         pop;
    logic [W-1:0] push_data;
    logic         push_src;

    // Readies depend only on registered occupancy, never on out_ready.
    assign can_push = (count != 2'd2);

    always_comb begin
        grant_as  = 1'b0;
        grant_mul = 1'b0;
        unique case (sel_mode)
            MODE_AS:  grant_as  = 1'b1;
            MODE_MUL: grant_mul = 1'b1;
            MODE_RR: begin
                if (as_valid && mul_valid) begin
                    grant_as  = rr_last;
                    grant_mul = !rr_last;
                end else begin
                    grant_as  = as_valid;
                    grant_mul = mul_valid;
                end
            end
            MODE_PRI: begin
                grant_mul = mul_valid;
                grant_as  = as_valid && !mul_valid;
            end
            default: ;
        endcase
    end

    assign as_ready  = can_push & grant_as;
    assign mul_ready = can_push & grant_mul;

    // Grants are mutually exclusive, so at most one push per cycle.
    always_comb begin
        push      = 1'b0;
        push_src  = 1'b0;
        push_data = '0;
        if (as_valid && as_ready) begin
            push      = 1'b1;
            push_src  = 1'b0;
            push_data = extend(as_data, ext_signed);
        end else if (mul_valid && mul_ready) begin
            push      = 1'b1;
            push_src  = 1'b1;
            push_data = mul_data;
        end
    end

    assign pop = out_valid & out_ready;

    // p1: buffer storage and control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_p1[i] <= '0;
                buf_src_p1[i]  <= 1'b0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            rr_last <= 1'b1;
        end else begin
            if (push) begin
                buf_data_p1[wr_ptr] <= push_data;
                buf_src_p1[wr_ptr]  <= push_src;
                wr_ptr              <= ~wr_ptr;
                rr_last             <= push_src;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_data  = buf_data_p1[rd_ptr];
    assign out_src   = buf_src_p1[rd_ptr];
    assign out_valid = (count != 2'd0);
    assign occupancy = count;

endmodule

// File: tb/tb_result_select_buf.sv
// Scoreboard bench for result_select_buf: a reference model predicts readies
// and occupancy, and a queue holds the expected output order.
module tb_result_select_buf;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] as_data;
    logic         as_valid;
    logic         as_ready;
    logic [W-1:0] mul_data;
    logic         mul_valid;
    logic         mul_ready;
    logic [1:0]   sel_mode;
    logic         ext_signed;
    logic [W-1:0] out_data;
    logic         out_src;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   occupancy;

    int vectors = 0;
    int miscompares = 0;

    logic [W:0]   sb [$];
    logic [W-1:0] out_log [$];
    int           m_cnt;
    logic         m_rr;
    logic         ga, gm, ear, emr, mpop;
    logic [W:0]   exp_e;

    result_select_buf #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .as_data(as_data), .as_valid(as_valid), .as_ready(as_ready),
        .mul_data(mul_data), .mul_valid(mul_valid), .mul_ready(mul_ready),
        .sel_mode(sel_mode), .ext_signed(ext_signed),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_ext(input logic [N-1:0] d, input logic s);
        logic [W-1:0] r;
        r = {W{s & d[N-1]}};
        r[N-1:0] = d;
        return r;
    endfunction

    // Reference model evaluated mid-cycle, while inputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_occupancy", occupancy, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_src", out_src, 0);
            m_cnt = 0;
            m_rr  = 1'b1;
            sb.delete();
        end else begin
            ga = 1'b0;
            gm = 1'b0;
            case (sel_mode)
                2'b00: ga = 1'b1;
                2'b01: gm = 1'b1;
                2'b10: begin
                    if (as_valid && mul_valid) begin
                        if (m_rr) ga = 1'b1; else gm = 1'b1;
                    end else begin
                        ga = as_valid;
                        gm = mul_valid;
                    end
                end
                default: begin
                    if (mul_valid) gm = 1'b1; else ga = as_valid;
                end
            endcase
            ear = (m_cnt < 2) && ga;
            emr = (m_cnt < 2) && gm;
            chk("as_ready", as_ready, ear);
            chk("mul_ready", mul_ready, emr);
            chk("occupancy", occupancy, m_cnt);
            chk("out_valid", out_valid, m_cnt != 0);
            mpop = (m_cnt != 0) && out_ready;
            if (mpop) begin
                exp_e = sb.pop_front();
                chk("out_data", out_data, exp_e[W-1:0]);
                chk("out_src", out_src, exp_e[W]);
                out_log.push_back(out_data);
            end
            if (as_valid && ear) begin
                sb.push_back({1'b0, ref_ext(as_data, ext_signed)});
                m_rr = 1'b0;
                m_cnt++;
            end else if (mul_valid && emr) begin
                sb.push_back({1'b1, mul_data});
                m_rr = 1'b1;
                m_cnt++;
            end
            if (mpop) m_cnt--;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        as_valid  = 1'b0;
        mul_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Holds mul_data offered until it is taken, within a cycle budget.
    task automatic offer_mul(input logic [W-1:0] d);
        bit taken = 0;
        mul_data  = d;
        mul_valid = 1'b1;
        for (int i = 0; i < 10 && !taken; i++) begin
            @(negedge clk);
            taken = mul_ready;
            @(posedge clk);
            #1;
        end
        mul_valid = 1'b0;
        if (!taken) chk("offer_mul_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; as_data = '0; as_valid = 1'b0; mul_data = '0; mul_valid = 1'b0;
        sel_mode = 2'b00; ext_signed = 1'b0; out_ready = 1'b0;
        step(1);
        do_reset();

        // Zero and sign extension
        sel_mode = 2'b00; out_ready = 1'b0; as_data = 4'hA; ext_signed = 1'b0; as_valid = 1'b1;
        step(1);
        as_valid = 1'b0;
        chk("ext_zero_valid", out_valid, 1);
        chk("ext_zero_data", out_data, 8'h0A);
        chk("ext_zero_src", out_src, 0);
        out_ready = 1'b1; step(1); out_ready = 1'b0;
        ext_signed = 1'b1; as_valid = 1'b1;
        step(1);
        as_valid = 1'b0;
        chk("ext_sign_data", out_data, 8'hFA);
        out_ready = 1'b1; step(2);

        // Round-robin from reset: add/sub first
        do_reset();
        out_log.delete();
        sel_mode = 2'b10; ext_signed = 1'b0; out_ready = 1'b1;
        as_data = 4'h3; mul_data = 8'h55; as_valid = 1'b1; mul_valid = 1'b1;
        step(4);
        idle(); step(2);
        chk("rr_count", out_log.size(), 4);
        if (out_log.size() == 4) begin
            chk("rr_0", out_log[0], 8'h03);
            chk("rr_1", out_log[1], 8'h55);
            chk("rr_2", out_log[2], 8'h03);
            chk("rr_3", out_log[3], 8'h55);
        end

        // Mul priority
        out_log.delete();
        sel_mode = 2'b11; as_data = 4'h5; as_valid = 1'b1; mul_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mul_data = 8'h81 + 8'(i);
            step(1);
        end
        mul_valid = 1'b0;
        step(1);
        idle(); step(2);
        chk("pri_count", out_log.size(), 4);
        if (out_log.size() == 4) begin
            chk("pri_0", out_log[0], 8'h81);
            chk("pri_2", out_log[2], 8'h83);
            chk("pri_3", out_log[3], 8'h05);
        end

        // Backpressure fills the buffer
        out_log.delete();
        sel_mode = 2'b01; out_ready = 1'b0; mul_valid = 1'b1;
        mul_data = 8'h11; step(1);
        mul_data = 8'h22; step(1);
        mul_data = 8'h33; step(2);
        chk("bp_occ_full", occupancy, 2);
        chk("bp_mul_ready", mul_ready, 0);
        chk("bp_head", out_data, 8'h11);
        out_ready = 1'b1;
        offer_mul(8'h33);
        step(3);
        chk("bp_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("bp_0", out_log[0], 8'h11);
            chk("bp_1", out_log[1], 8'h22);
            chk("bp_2", out_log[2], 8'h33);
        end

        // Continuous stream with simultaneous push and pop
        sel_mode = 2'b01; out_ready = 1'b1; mul_valid = 1'b1;
        mul_data = 8'h40; step(1);
        for (int i = 1; i < 6; i++) begin
            mul_data = 8'h40 + 8'(i);
            chk("stream_occ", occupancy, 1);
            chk("stream_ready", mul_ready, 1);
            chk("stream_head", out_data, 8'h40 + 8'(i - 1));
            step(1);
        end
        idle(); step(2);

        // Asynchronous reset with a full buffer
        sel_mode = 2'b01; out_ready = 1'b0; mul_valid = 1'b1;
        mul_data = 8'hC1; step(1);
        mul_data = 8'hC2; step(1);
        idle();
        chk("pre_rst_occ", occupancy, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_occ", occupancy, 0);
        step(2);
        rst_n = 1'b1;
        sel_mode = 2'b10; out_ready = 1'b1; as_data = 4'h7; mul_data = 8'h99;
        as_valid = 1'b1; mul_valid = 1'b1;
        step(1);
        idle();
        chk("post_rst_src", out_src, 0);
        chk("post_rst_data", out_data, 8'h07);
        step(3);
        chk("final_empty", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
